dmem_sized_access: RTL
======================

// Module: dmem_sized_access
// PURPOSE
//  Byte-addressed, big-endian data memory for the MIPS core with a valid/ready request port,
//  sized accesses (byte/half/word), sign/zero extension for loads and a programmable
//  wait-state counter. Serves LB/LBU/LH/LHU/LW/SB/SH/SW from the MEM stage, one request in flight.
// PARAMETERS
//  ADDR_WIDTH   10  byte-address bits used; depth = 2**ADDR_WIDTH bytes, upper req_addr bits ignored
//  WAIT_CYCLES  0   extra wait states per access, 0..15
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept a request this cycle
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   one-cycle response pulse (loads and stores)
//  rsp_rdata    out  32  load data, extended to 32 bits; 0 for stores
//  rsp_err      out  1   access error, valid with rsp_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    wait counter 0. Memory array is NOT cleared.
//  - FSM IDLE/BUSY/RESP. req_ready=1 only in IDLE. Accept = req_valid & req_ready at edge E0:
//    capture we/size/unsigned/addr/wdata, load counter=WAIT_CYCLES, go BUSY.
//  - BUSY: counter!=0 -> decrement; counter==0 -> perform access, go RESP.
//  - RESP: rsp_valid=1 for exactly one cycle, starting at edge E0+WAIT_CYCLES+1; then IDLE.
//    rsp_rdata/rsp_err hold their value until the next response; rsp_valid returns to 0.
//  - Throughput: one access per WAIT_CYCLES+3 cycles; req_valid outside IDLE is not accepted.
//  - Effective address = req_addr[ADDR_WIDTH-1:0]; byte index arithmetic wraps modulo depth.
//  - Big-endian: word at A -> {M[A],M[A+1],M[A+2],M[A+3]}; half -> {M[A],M[A+1]}.
//  - Store writes only the addressed bytes (1/2/4); other bytes unchanged. Commit occurs at
//    the BUSY->RESP edge; reset before that edge aborts the store with memory unmodified.
//  - Load extension: byte bit7 / half bit15 replicated if req_unsigned=0, else zeros.
//  - Reset during BUSY or RESP: FSM to IDLE, no rsp_valid is ever issued for that request.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//   - Error if size=01 & addr[0]=1, size=10 & addr[1:0]!=0, or size=11.
//   - Errored request: same timing, no memory write, rsp_rdata=0, rsp_err=1.
//  DMEM_ALIGN_CHECK_EN undefined:
//   - No check; misaligned access done bytewise at A..A+n-1 with wrap; size=11 treated as word;
//     rsp_err tied 0.
// TESTING
//  1. Reset then SW 0x12345678 @0x10, LW @0x10 -> rsp_rdata=0x12345678, rsp_err=0;
//     LBU @0x10 -> 0x00000012; LBU @0x13 -> 0x00000078.
//  2. SB 0x80 @0x21 over word 0 at 0x20, LB @0x21 -> 0xFFFFFF80, LBU -> 0x00000080,
//     LW @0x20 -> 0x00800000; SH 0xBEEF @0x22, LH -> 0xFFFFBEEF, LHU -> 0x0000BEEF.
//  3. WAIT_CYCLES=3: accept at edge 0 -> rsp_valid high only after edge 4, req_ready=0 on edges 1..4;
//     req_valid held high during BUSY is not accepted a second time.
//  4. ADDR_WIDTH=10: SW 0xAABBCCDD @0x400 then LW @0x000 -> 0xAABBCCDD (upper bits ignored);
//     without DMEM_ALIGN_CHECK_EN, SW 0x11223344 @0x3FE -> LBU @0x3FF=0x22, @0x000=0x33.
//  5. DMEM_ALIGN_CHECK_EN: LW @0x02, SH @0x01, size=11 -> rsp_err=1, rsp_rdata=0, memory unchanged
//     (LW @0x00 returns prior value).
//  6. WAIT_CYCLES=2: SW 0xDEADBEEF @0x40, assert rst_n=0 one cycle after accept -> no rsp_valid,
//     outputs 0, req_ready=1; subsequent LW @0x40 returns pre-store contents.

Source files
------------

// File: rtl/dmem_sized_access.sv
// Byte-addressed, big-endian data memory with a valid/ready request port.
// Serves byte/half/word loads and stores, one request in flight, with a
// programmable number of wait states.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned or illegal-size
// accesses; otherwise misaligned accesses are performed bytewise with wrap.
module dmem_sized_access #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic                  r_we;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rdata;
   logic                  r_err;
   logic [7:0]            r_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] w_a1;
   logic [ADDR_WIDTH-1:0] w_a2;
   logic [ADDR_WIDTH-1:0] w_a3;
   logic [7:0]            w_b0;
   logic [7:0]            w_b1;
   logic [7:0]            w_b2;
   logic [7:0]            w_b3;
   logic [31:0]           w_load;
   logic                  w_err;
   logic                  w_access;
   logic                  w_unused_addr;

   // Address bits above the array depth are deliberately ignored.
   assign w_unused_addr = ^req_addr[31:ADDR_WIDTH];

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // The access happens on the last BUSY cycle (counter exhausted).
   assign w_access = (r_state == ST_BUSY) && (r_cnt == 4'd0);

   // Byte lanes wrap naturally modulo the array depth.
   assign w_a1 = r_addr + ADDR_WIDTH'(1);
   assign w_a2 = r_addr + ADDR_WIDTH'(2);
   assign w_a3 = r_addr + ADDR_WIDTH'(3);
   assign w_b0 = r_mem[r_addr];
   assign w_b1 = r_mem[w_a1];
   assign w_b2 = r_mem[w_a2];
   assign w_b3 = r_mem[w_a3];

`ifdef DMEM_ALIGN_CHECK_EN
   // Flag misaligned halves/words and the reserved size encoding.
   always_comb begin
      w_err = 1'b0;
      case (r_size)
         SZ_HALF: w_err = r_addr[0];
         SZ_WORD: w_err = (r_addr[1:0] != 2'b00);
         SZ_BYTE: w_err = 1'b0;
         default: w_err = 1'b1;
      endcase
   end
`else
   assign w_err = 1'b0;
`endif

   // Assemble the big-endian load value and apply sign/zero extension.
   always_comb begin
      w_load = 32'h0;
      case (r_size)
         SZ_BYTE: w_load = r_uns ? {24'h0, w_b0} : {{24{w_b0[7]}}, w_b0};
         SZ_HALF: w_load = r_uns ? {16'h0, w_b0, w_b1} : {{16{w_b0[7]}}, w_b0, w_b1};
         default: w_load = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

   // Request/response FSM; captures the request and produces the response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_size  <= req_size;
                  r_uns   <= req_unsigned;
                  r_addr  <= req_addr[ADDR_WIDTH-1:0];
                  r_wdata <= req_wdata;
                  r_cnt   <= LP_WAIT;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_err   <= w_err;
                  r_rdata <= (r_we || w_err) ? 32'h0 : w_load;
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Store commit; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (w_access && r_we && !w_err) begin
         case (r_size)
            SZ_BYTE: r_mem[r_addr] <= r_wdata[7:0];
            SZ_HALF: begin
               r_mem[r_addr] <= r_wdata[15:8];
               r_mem[w_a1]   <= r_wdata[7:0];
            end
            default: begin
               r_mem[r_addr] <= r_wdata[31:24];
               r_mem[w_a1]   <= r_wdata[23:16];
               r_mem[w_a2]   <= r_wdata[15:8];
               r_mem[w_a3]   <= r_wdata[7:0];
            end
         endcase
      end
   end

endmodule
